// File: rtl/adder_input_seq_pkg.sv
// Shared definitions for the adder operand sequencer.
// Holds the state encoding that is also exported on state_o for the display,
// so the display mux and the sequencer agree on the numeric codes.
package adder_input_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_WAIT_A = 2'd0,
        ST_WAIT_B = 2'd1,
        ST_REQ    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/adder_hist_buf.sv
// Circular history of completed adder sums.
// Ports:
//   clk, resetn  : clock, async active-low reset (clears all entries)
//   push         : store push_data as the newest entry
//   push_data    : sum to store
//   rd_idx       : slot to read, 0 = most recent
//   rd_data      : registered read data (1-cycle latency), 0 for empty slots
//   count        : number of valid entries, saturates at DEPTH
module adder_hist_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic [IDX_W:0]   count
);

    localparam logic [IDX_W:0] FULL = (IDX_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W-1:0] rd_slot;
    logic             rd_hit;

    // Newest entry sits just behind the write pointer; DEPTH is a power of
    // two so the subtraction wraps for free.
    assign rd_slot = wr_ptr - IDX_W'(1) - rd_idx;
    assign rd_hit  = ({1'b0, rd_idx} < count);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + IDX_W'(1);
            if (count != FULL) begin
                count <= count + (IDX_W+1)'(1);
            end
        end
    end

    // Reads of slots that were never written return 0 rather than stale data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_hit ? mem[rd_slot] : '0;
        end
    end

endmodule

// File: rtl/adder_input_seq.sv
// Operand sequencer between the touch-screen input path and a multi-cycle adder.
// Collects operand A then operand B (with the carry-in switch), runs one req/ack
// transaction, holds the result for the display and records it in a history.
// Ports:
//   clk, resetn              : clock, async active-low reset
//   input_valid/input_value  : one-cycle operand pulse from the screen
//   sw_cin                   : carry-in switch, sampled with operand B
//   clear                    : abort to WAIT_A, results and history kept
//   add_a/add_b/add_cin      : operands to the adder
//   add_req/add_ack          : request held until ack; add_sum/add_cout valid with ack
//   res_sum/res_cout         : last completed result
//   res_valid                : high while in DONE
//   timeout_err              : last transaction got no ack in time
//   state_o                  : current state code
//   op_count                 : completed transaction count (wraps)
//   hist_rd_idx/hist_rd_data : history read, 0 = most recent, 1-cycle latency
//   hist_count               : valid history entries
module adder_input_seq
    import adder_input_seq_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int TIMEOUT    = 255,
    parameter int HIST_DEPTH = 4,
    localparam int IDX_W     = $clog2(HIST_DEPTH)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               input_valid,
    input  logic [WIDTH-1:0]   input_value,
    input  logic               sw_cin,
    input  logic               clear,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    output logic               add_req,
    input  logic               add_ack,
    input  logic [WIDTH-1:0]   add_sum,
    input  logic               add_cout,
    output logic [WIDTH-1:0]   res_sum,
    output logic               res_cout,
    output logic               res_valid,
    output logic               timeout_err,
    output logic [STATE_W-1:0] state_o,
    output logic [15:0]        op_count,
    input  logic [IDX_W-1:0]   hist_rd_idx,
    output logic [WIDTH-1:0]   hist_rd_data,
    output logic [IDX_W:0]     hist_count
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_V = TIMEOUT[TW-1:0];

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic          load_a;
    logic          load_b;
    logic          do_clear;
    logic          ack_ok;
    logic          timed_out;

    assign state_o   = state;
    assign res_valid = (state == ST_DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_WAIT_A;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode. clear overrides everything, including an operand
    // pulse or an ack arriving in the same cycle. In REQ an ack landing on
    // the final timer cycle still counts as a success.
    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        do_clear   = 1'b0;
        ack_ok     = 1'b0;
        timed_out  = 1'b0;
        if (clear) begin
            do_clear   = 1'b1;
            state_next = ST_WAIT_A;
        end else begin
            case (state)
                ST_WAIT_A, ST_DONE: begin
                    if (input_valid) begin
                        load_a     = 1'b1;
                        state_next = ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (input_valid) begin
                        load_b     = 1'b1;
                        state_next = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (add_ack) begin
                        ack_ok     = 1'b1;
                        state_next = ST_DONE;
                    end else if (timer == TIMEOUT_V) begin
                        timed_out  = 1'b1;
                        state_next = ST_DONE;
                    end
                end
                default: begin
                    state_next = ST_WAIT_A;
                end
            endcase
        end
    end

    // Operand, request and result registers driven by the decoded strobes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            add_a       <= '0;
            add_b       <= '0;
            add_cin     <= 1'b0;
            add_req     <= 1'b0;
            res_sum     <= '0;
            res_cout    <= 1'b0;
            timeout_err <= 1'b0;
            op_count    <= '0;
        end else begin
            if (do_clear) begin
                add_a   <= '0;
                add_b   <= '0;
                add_cin <= 1'b0;
                add_req <= 1'b0;
            end
            if (load_a) begin
                add_a <= input_value;
            end
            if (load_b) begin
                add_b   <= input_value;
                add_cin <= sw_cin;
                add_req <= 1'b1;
            end
            if (ack_ok) begin
                res_sum     <= add_sum;
                res_cout    <= add_cout;
                timeout_err <= 1'b0;
                op_count    <= op_count + 16'd1;
                add_req     <= 1'b0;
            end
            if (timed_out) begin
                add_req     <= 1'b0;
                timeout_err <= 1'b1;
            end
        end
    end

    // The timer reads 0 on the first REQ cycle and advances once per cycle
    // spent waiting, so the request stays up for TIMEOUT+1 cycles at most.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer <= '0;
        end else if (state == ST_REQ && state_next == ST_REQ) begin
            timer <= timer + TW'(1);
        end else begin
            timer <= '0;
        end
    end

    adder_hist_buf #(
        .WIDTH (WIDTH),
        .DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk       (clk),
        .resetn    (resetn),
        .push      (ack_ok),
        .push_data (add_sum),
        .rd_idx    (hist_rd_idx),
        .rd_data   (hist_rd_data),
        .count     (hist_count)
    );

endmodule

// File: tb/tb_adder_input_seq.sv
module tb_adder_input_seq;

    localparam int WIDTH      = 32;
    localparam int TIMEOUT    = 16;
    localparam int HIST_DEPTH = 4;
    localparam int IDX_W      = 2;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             input_valid = 1'b0;
    logic [WIDTH-1:0] input_value = '0;
    logic             sw_cin = 1'b0;
    logic             clear = 1'b0;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic             add_req;
    logic             add_ack = 1'b0;
    logic [WIDTH-1:0] add_sum = '0;
    logic             add_cout = 1'b0;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_valid;
    logic             timeout_err;
    logic [1:0]       state_o;
    logic [15:0]      op_count;
    logic [IDX_W-1:0] hist_rd_idx = '0;
    logic [WIDTH-1:0] hist_rd_data;
    logic [IDX_W:0]   hist_count;

    adder_input_seq #(
        .WIDTH      (WIDTH),
        .TIMEOUT    (TIMEOUT),
        .HIST_DEPTH (HIST_DEPTH)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .input_valid  (input_valid),
        .input_value  (input_value),
        .sw_cin       (sw_cin),
        .clear        (clear),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_cin      (add_cin),
        .add_req      (add_req),
        .add_ack      (add_ack),
        .add_sum      (add_sum),
        .add_cout     (add_cout),
        .res_sum      (res_sum),
        .res_cout     (res_cout),
        .res_valid    (res_valid),
        .timeout_err  (timeout_err),
        .state_o      (state_o),
        .op_count     (op_count),
        .hist_rd_idx  (hist_rd_idx),
        .hist_rd_data (hist_rd_data),
        .hist_count   (hist_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: the visible result registers plus the history as a
    // newest-first list of successful sums.
    logic [WIDTH-1:0] m_res_sum;
    logic             m_res_cout;
    logic             m_terr;
    logic [15:0]      m_ops;
    logic [WIDTH-1:0] m_hist[$];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_res_sum  = '0;
        m_res_cout = 1'b0;
        m_terr     = 1'b0;
        m_ops      = '0;
        m_hist.delete();
    endtask

    task automatic checkResults(input string tag);
        checkOutput({tag, "_res_sum"}, res_sum, m_res_sum);
        checkOutput({tag, "_res_cout"}, res_cout, m_res_cout);
        checkOutput({tag, "_timeout_err"}, timeout_err, m_terr);
        checkOutput({tag, "_op_count"}, op_count, m_ops);
    endtask

    task automatic checkHistory(input string tag);
        logic [WIDTH-1:0] exp;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            hist_rd_idx = IDX_W'(i);
            @(negedge clk);
            exp = (i < m_hist.size()) ? m_hist[i] : '0;
            checkOutput($sformatf("%s_hist%0d", tag, i), hist_rd_data, exp);
        end
        checkOutput({tag, "_hist_count"}, hist_count, m_hist.size());
    endtask

    task automatic pulseOperand(input logic [WIDTH-1:0] v, input logic cin);
        input_valid = 1'b1;
        input_value = v;
        sw_cin      = cin;
        @(negedge clk);
        input_valid = 1'b0;
        sw_cin      = 1'($urandom_range(0, 1));
    endtask

    // Enter both operands and play the adder: acknowledge on the given REQ
    // cycle (0 = first cycle add_req is seen high). A delay beyond TIMEOUT
    // means the adder never answers.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input int delay);
        logic [WIDTH:0] full;
        int             n;
        bit             ok;
        full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        pulseOperand(a, 1'b0);
        checkOutput("state_wait_b", state_o, 2'd1);
        pulseOperand(b, cin);
        checkOutput("req_rise", add_req, 1'b1);
        checkOutput("state_req", state_o, 2'd2);
        checkOutput("op_a", add_a, a);
        checkOutput("op_b", add_b, b);
        checkOutput("op_cin", add_cin, cin);
        n = 0;
        while (add_req === 1'b1 && n < TIMEOUT + 5) begin
            add_ack     = (n == delay);
            add_sum     = full[WIDTH-1:0];
            add_cout    = full[WIDTH];
            input_valid = 1'($urandom_range(0, 1));
            input_value = $urandom;
            @(negedge clk);
            n++;
        end
        add_ack     = 1'b0;
        input_valid = 1'b0;
        ok = (delay <= TIMEOUT);
        checkOutput("req_cycles", n, ok ? delay + 1 : TIMEOUT + 1);
        if (ok) begin
            m_res_sum  = full[WIDTH-1:0];
            m_res_cout = full[WIDTH];
            m_terr     = 1'b0;
            m_ops      = m_ops + 16'd1;
            m_hist.push_front(full[WIDTH-1:0]);
            if (m_hist.size() > HIST_DEPTH) begin
                void'(m_hist.pop_back());
            end
        end else begin
            m_terr = 1'b1;
        end
        checkOutput("state_done", state_o, 2'd3);
        checkOutput("res_valid", res_valid, 1'b1);
        checkOutput("a_held", add_a, a);
        checkOutput("b_held", add_b, b);
        checkResults("txn");
    endtask

    // Start a transaction, then clear on the first REQ cycle and send a late
    // ack that must be ignored.
    task automatic applyClearInReq(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        pulseOperand(a, 1'b0);
        pulseOperand(b, 1'b1);
        checkOutput("clr_req_high", add_req, 1'b1);
        clear = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        add_ack  = 1'b1;
        add_sum  = $urandom;
        add_cout = 1'b1;
        @(negedge clk);
        add_ack = 1'b0;
        checkOutput("clr_state", state_o, 2'd0);
        checkOutput("clr_req", add_req, 1'b0);
        checkOutput("clr_a", add_a, '0);
        checkOutput("clr_b", add_b, '0);
        checkOutput("clr_cin", add_cin, 1'b0);
        checkOutput("clr_res_valid", res_valid, 1'b0);
        checkResults("clr");
    endtask

    initial begin
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("rst_state", state_o, 2'd0);
        checkOutput("rst_req", add_req, 1'b0);
        checkOutput("rst_hist_data", hist_rd_data, '0);
        checkOutput("rst_hist_count", hist_count, '0);
        checkResults("rst");
        resetn = 1'b1;
        @(negedge clk);

        // Small positive operands with carry-in, ack on the third REQ cycle.
        applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b1, 2);
        checkOutput("t1_sum", res_sum, 32'd9);
        checkHistory("t1");

        // Wrap-around: sum 0 with carry-out.
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        checkOutput("t2_cout", res_cout, 1'b1);

        // No ack at all: timeout, result kept.
        applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, TIMEOUT + 10);
        checkOutput("t3_terr", timeout_err, 1'b1);

        // Ack on the last timer cycle still succeeds and clears the error.
        applyStimulus(32'h0000_0100, 32'h0000_0200, 1'b1, TIMEOUT);

        // Five transactions with sums 1..5 fill and wrap the history.
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(32'd0, WIDTH'(i), 1'b0, i % 3);
        end
        checkHistory("t4");

        // An ack while idle in DONE changes nothing.
        add_ack  = 1'b1;
        add_sum  = 32'hDEAD_BEEF;
        add_cout = 1'b1;
        @(negedge clk);
        add_ack = 1'b0;
        checkOutput("idle_ack_state", state_o, 2'd3);
        checkResults("idle_ack");

        // clear with an operand pulse in the same cycle: clear wins.
        clear       = 1'b1;
        input_valid = 1'b1;
        input_value = 32'hCAFE_0001;
        @(negedge clk);
        clear       = 1'b0;
        input_valid = 1'b0;
        checkOutput("clr_iv_state", state_o, 2'd0);
        checkOutput("clr_iv_a", add_a, '0);
        checkResults("clr_iv");

        applyClearInReq(32'h0000_0007, 32'h0000_0008);

        // Randomized transactions, some timing out, some aborted by clear.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                applyClearInReq($urandom, $urandom);
            end else begin
                applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)),
                              int'($urandom_range(0, TIMEOUT + 3)));
            end
        end
        checkHistory("rand");

        // Asynchronous reset in the middle of a request.
        pulseOperand(32'h0000_00AA, 1'b0);
        pulseOperand(32'h0000_0055, 1'b1);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        modelReset();
        checkOutput("arst_state", state_o, 2'd0);
        checkOutput("arst_req", add_req, 1'b0);
        checkOutput("arst_a", add_a, '0);
        checkOutput("arst_b", add_b, '0);
        checkOutput("arst_res_valid", res_valid, 1'b0);
        checkOutput("arst_hist_data", hist_rd_data, '0);
        checkOutput("arst_hist_count", hist_count, '0);
        checkResults("arst");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        applyStimulus(32'h0000_0002, 32'h0000_0002, 1'b0, 1);
        checkHistory("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
